// File: rtl/mem_access_stage.sv
// MEM stage: turns EX_MEM load/store controls into a req/ack data-memory
// transaction with lane alignment, load extension, stall, misalign and timeout.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_load;
  logic          r_misal;
  logic          r_berr;
  logic [1:0]    r_sz;
  logic          r_uns;
  logic [1:0]    r_off;

  logic          w_access;
  logic          w_we;
  logic [1:0]    w_sz;
  logic          w_misal;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;

  assign w_access = ex_valid & (mem_read | mem_write);
  assign w_we     = mem_write & ~mem_read;
  assign w_sz     = funct3[1] ? SZ_W : (funct3[0] ? SZ_H : SZ_B);
  assign w_misal  = ((w_sz == SZ_H) & addr[0]) |
                    ((w_sz == SZ_W) & (|addr[1:0]));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    unique case (1'b1)
      (w_sz == SZ_B): begin
        w_wdata = {4{store_data[7:0]}};
        if (w_we) w_be = 4'b0001 << addr[1:0];
      end
      (w_sz == SZ_H): begin
        w_wdata = {2{store_data[15:0]}};
        if (w_we) w_be = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Lane select uses the offset captured at issue, not the live address.
  always_comb begin
    w_byte = dmem_rdata[7:0];
    unique case (r_off)
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      2'd3:    w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_ext  = dmem_rdata;
    unique case (1'b1)
      (r_sz == SZ_B):
        w_ext = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      (r_sz == SZ_H):
        w_ext = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_load  <= '0;
      r_misal <= 1'b0;
      r_berr  <= 1'b0;
      r_sz    <= SZ_B;
      r_uns   <= 1'b0;
      r_off   <= '0;
    end else begin
      r_misal <= 1'b0;
      r_berr  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_access && w_misal) begin
            r_misal <= 1'b1;
            r_load  <= '0;
          end else if (w_access) begin
            r_req   <= 1'b1;
            r_we    <= w_we;
            r_addr  <= {addr[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_cnt   <= '0;
            r_sz    <= w_sz;
            r_uns   <= funct3[2];
            r_off   <= addr[1:0];
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            if (!r_we) r_load <= w_ext;
            r_req   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == LAST) begin
            r_req   <= 1'b0;
            r_berr  <= 1'b1;
            r_load  <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_stall  = rst & ((r_state == S_BUSY) |
                      ((r_state == S_IDLE) & w_access & ~w_misal));
  assign load_data  = r_load;
  assign misalign   = r_misal;
  assign bus_err    = r_berr;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalign,
// bus timeout and mid-transaction reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        mem_stall;
  logic        misalign;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  // captured by txn
  int          c_stalls;
  logic        c_breq;
  logic        c_bwe;
  logic [31:0] c_baddr;
  logic [31:0] c_bwdata;
  logic [3:0]  c_bbe;
  logic [31:0] c_ld;
  logic        c_dstall;
  logic        c_dreq;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .mem_stall(mem_stall),
    .misalign(misalign), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One access with ack in the first BUSY cycle; records what it observed.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rdata);
    @(negedge clk);
    ex_valid = 1'b1; mem_read = rd; mem_write = wr;
    funct3 = f3; addr = a; store_data = sd;
    #1;
    c_stalls = int'(mem_stall);
    @(negedge clk);
    c_stalls += int'(mem_stall);
    c_breq = dmem_req; c_bwe = dmem_we; c_baddr = dmem_addr;
    c_bwdata = dmem_wdata; c_bbe = dmem_be;
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_ack = 1'b0;
    c_ld = load_data; c_dstall = mem_stall; c_dreq = dmem_req;
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1000;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({dmem_req, mem_stall, misalign, bus_err, dmem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 00000",
        {dmem_req, mem_stall, misalign, bus_err, dmem_we}); end
    n_chk++; if ({load_data, dmem_addr, dmem_wdata, dmem_be} !== 100'b0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h expected zeros",
        load_data, dmem_addr, dmem_wdata, dmem_be); end
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_lw;
    txn(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF);
    n_chk++; if (c_stalls !== 2) begin
      n_fail++; $display("FAIL lw_stalls: got %0d expected 2", c_stalls); end
    n_chk++; if (c_breq !== 1'b1 || c_bwe !== 1'b0) begin
      n_fail++; $display("FAIL lw_req: got req=%b we=%b expected 1 0", c_breq, c_bwe); end
    n_chk++; if (c_baddr !== 32'h1000 || c_bbe !== 4'b1111) begin
      n_fail++; $display("FAIL lw_addr_be: got %h %b expected 00001000 1111", c_baddr, c_bbe); end
    n_chk++; if (c_ld !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_data: got %h expected deadbeef", c_ld); end
    n_chk++; if (c_dstall !== 1'b0 || c_dreq !== 1'b0) begin
      n_fail++; $display("FAIL lw_done: got stall=%b req=%b expected 0 0", c_dstall, c_dreq); end
  endtask

  task automatic test_load_extend;
    txn(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FFFFFF);
    n_chk++; if (c_ld !== 32'hFFFFFF80) begin
      n_fail++; $display("FAIL lb: got %h expected ffffff80", c_ld); end
    n_chk++; if (c_baddr !== 32'h1000) begin
      n_fail++; $display("FAIL lb_addr: got %h expected 00001000", c_baddr); end
    txn(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FFFFFF);
    n_chk++; if (c_ld !== 32'h00000080) begin
      n_fail++; $display("FAIL lbu: got %h expected 00000080", c_ld); end
    txn(1'b1, 1'b0, 3'b001, 32'h1000, 32'h0, 32'h00008001);
    n_chk++; if (c_ld !== 32'hFFFF8001) begin
      n_fail++; $display("FAIL lh: got %h expected ffff8001", c_ld); end
    txn(1'b1, 1'b0, 3'b011, 32'h1004, 32'h0, 32'h89ABCDEF);
    n_chk++; if (c_ld !== 32'h89ABCDEF) begin
      n_fail++; $display("FAIL f3_011_as_w: got %h expected 89abcdef", c_ld); end
    txn(1'b1, 1'b0, 3'b101, 32'h1002, 32'h0, 32'h80FFFFFF);
    n_chk++; if (c_ld !== 32'h000080FF) begin
      n_fail++; $display("FAIL lhu: got %h expected 000080ff", c_ld); end
  endtask

  task automatic test_store;
    txn(1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h55555555);
    n_chk++; if (c_bwe !== 1'b1 || c_bbe !== 4'b1100) begin
      n_fail++; $display("FAIL sh_we_be: got %b %b expected 1 1100", c_bwe, c_bbe); end
    n_chk++; if (c_bwdata !== 32'hABCDABCD || c_baddr !== 32'h2000) begin
      n_fail++; $display("FAIL sh_wdata_addr: got %h %h expected abcdabcd 00002000",
        c_bwdata, c_baddr); end
    n_chk++; if (c_ld !== 32'h000080FF) begin
      n_fail++; $display("FAIL sh_load_kept: got %h expected 000080ff", c_ld); end
    txn(1'b0, 1'b1, 3'b000, 32'h2001, 32'h000000AB, 32'h0);
    n_chk++; if (c_bbe !== 4'b0010 || c_bwdata !== 32'hABABABAB) begin
      n_fail++; $display("FAIL sb: got %b %h expected 0010 abababab", c_bbe, c_bwdata); end
    txn(1'b0, 1'b1, 3'b010, 32'h2008, 32'hCAFEBABE, 32'h0);
    n_chk++; if (c_bbe !== 4'b1111 || c_bwdata !== 32'hCAFEBABE) begin
      n_fail++; $display("FAIL sw: got %b %h expected 1111 cafebabe", c_bbe, c_bwdata); end
    txn(1'b1, 1'b1, 3'b010, 32'h3000, 32'h11111111, 32'hCAFEF00D);
    n_chk++; if (c_bwe !== 1'b0 || c_ld !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rd_wins: got we=%b ld=%h expected 0 cafef00d", c_bwe, c_ld); end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1001;
    #1;
    n_chk++; if (mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL mis_stall: got %b expected 0", mem_stall); end
    @(posedge clk); #1;
    n_chk++; if (misalign !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL mis_pulse: got mis=%b req=%b expected 1 0", misalign, dmem_req); end
    n_chk++; if (load_data !== 32'h0) begin
      n_fail++; $display("FAIL mis_load: got %h expected 0", load_data); end
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (misalign !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL mis_clear: got mis=%b req=%b expected 0 0", misalign, dmem_req); end
  endtask

  task automatic test_timeout;
    int reqs = 0;
    int errs = 0;
    logic [31:0] ld = 'x;
    logic st = 1'bx;
    txn(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h11111111);
    @(negedge clk);
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1000;
    for (int i = 0; i < 40 && errs == 0; i++) begin
      @(negedge clk);
      if (dmem_req) reqs++;
      if (bus_err) begin
        errs++; ld = load_data; st = mem_stall;
        ex_valid = 1'b0; mem_read = 1'b0;
      end
    end
    n_chk++; if (reqs !== 16) begin
      n_fail++; $display("FAIL to_req_cycles: got %0d expected 16", reqs); end
    n_chk++; if (errs !== 1) begin
      n_fail++; $display("FAIL to_bus_err: got %0d expected 1", errs); end
    n_chk++; if (ld !== 32'h0 || st !== 1'b0) begin
      n_fail++; $display("FAIL to_done: got ld=%h stall=%b expected 0 0", ld, st); end
    @(negedge clk);
    n_chk++; if (bus_err !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse_len: got %b expected 0", bus_err); end
  endtask

  task automatic test_reset_mid_busy;
    txn(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h22222222);
    @(negedge clk);
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1000;
    @(negedge clk);
    n_chk++; if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL rb_busy: got %b expected 1", dmem_req); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({dmem_req, mem_stall} !== 2'b00 || load_data !== 32'h0) begin
      n_fail++; $display("FAIL rb_async: got req=%b stall=%b ld=%h expected 0 0 0",
        dmem_req, mem_stall, load_data); end
    ex_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h33333333;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_chk++; if ({dmem_req, mem_stall} !== 2'b00 || load_data !== 32'h0) begin
      n_fail++; $display("FAIL rb_late_ack: got req=%b stall=%b ld=%h expected 0 0 0",
        dmem_req, mem_stall, load_data); end
    txn(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h44444444);
    n_chk++; if (c_stalls !== 2 || c_ld !== 32'h44444444) begin
      n_fail++; $display("FAIL rb_recover: got %0d %h expected 2 44444444", c_stalls, c_ld); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
